// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, state enum and access-size helpers for the load/store unit
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds the ERR state).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_LOAD_RSP
`ifdef LSU_MISALIGN_TRAP_EN
    , S_ERR
`endif
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Unsigned byte/half encodings only exist for loads; stores treat them as words.
  function automatic lsu_size_t access_size(input logic is_load, input logic [2:0] f3);
    if (f3 == F3_W) return SZ_W;
    if (f3 == F3_B || (is_load && f3 == F3_BU)) return SZ_B;
    if (f3 == F3_H || (is_load && f3 == F3_HU)) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic [1:0] align_off(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - combinational lane select and sign/zero extension of load data
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rd_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      default: data_o = mem_rd_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between execute stage and word-addressed data memory
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests trap instead of aligning down).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [2:0]                Funct3,
  input  logic [DM_ADDRESS-1:0]     addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DM_ADDRESS-1:0]     mem_addr,
  output logic                      mem_we,
  output logic [BYTES_PER_WORD-1:0] mem_be,
  output logic [DATA_W-1:0]         mem_wd,
  output logic                      mem_re,
  input  logic [DATA_W-1:0]         mem_rd,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                      misalign
`endif
);

  lsu_state_t                state_q;
  logic [2:0]                f3_q;
  logic [1:0]                off_q;
  logic                      is_load_q;
  logic [DM_ADDRESS-1:0]     mem_addr_q;
  logic                      mem_we_q;
  logic                      mem_re_q;
  logic [BYTES_PER_WORD-1:0] mem_be_q;
  logic [DATA_W-1:0]         mem_wd_q;
  logic                      resp_valid_q;
  logic [DATA_W-1:0]         rdata_q;

  lsu_size_t                 req_size;
  logic [1:0]                req_off;
  logic [BYTES_PER_WORD-1:0] st_be;
  logic [DATA_W-1:0]         st_wd;
  logic                      accept;
  logic [DATA_W-1:0]         load_data;

  assign accept = req_valid && (state_q == S_IDLE) && (MemRead || MemWrite);

  // Load wins when both controls are set, so size decode follows MemRead.
  always_comb begin
    req_size = access_size(MemRead, Funct3);
    req_off  = align_off(req_size, addr[1:0]);
    st_be    = 4'b1111;
    st_wd    = wdata;
    case (req_size)
      SZ_B: begin
        st_be = 4'b0001 << req_off;
        st_wd = {4{wdata[7:0]}};
      end
      SZ_H: begin
        st_be = 4'b0011 << req_off;
        st_wd = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_misaligned;
  logic misalign_q;
  assign req_misaligned = ((req_size == SZ_H) && addr[0]) ||
                          ((req_size == SZ_W) && (addr[1:0] != 2'b00));
  assign misalign = misalign_q;
`endif

  load_formatter u_load_formatter (
    .mem_rd_i (mem_rd),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      is_load_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      // Memory strobes and the response are single-cycle pulses.
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (req_misaligned) begin
              state_q      <= S_ERR;
              resp_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
              rdata_q      <= '0;
            end else
`endif
            begin
              state_q    <= S_ACCESS;
              f3_q       <= Funct3;
              off_q      <= req_off;
              is_load_q  <= MemRead;
              mem_addr_q <= {addr[DM_ADDRESS-1:2], 2'b00};
              if (MemRead) begin
                mem_re_q <= 1'b1;
              end else begin
                mem_we_q     <= 1'b1;
                mem_be_q     <= st_be;
                mem_wd_q     <= st_wd;
                resp_valid_q <= 1'b1;
                rdata_q      <= '0;
              end
            end
          end
        end
        S_ACCESS: begin
          if (is_load_q) begin
            state_q      <= S_LOAD_RSP;
            resp_valid_q <= 1'b1;
            rdata_q      <= load_data;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD_RSP: state_q <= S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        S_ERR:      state_q <= S_IDLE;
`endif
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_be     = mem_be_q;
  assign mem_wd     = mem_wd_q;
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Load/store unit directly upstream of the data memory.
- Accepts memory requests from the execute stage: the ALU address, the store data (rs2), the MemRead/MemWrite controls and Funct3.
- Drives the word-addressed memory port with byte-lane write enables and lane-shifted store data.
- Formats load data by lane selection and sign/zero extension, and returns it to writeback with a valid strobe.
- Provides a busy/stall indication while a transaction is in flight.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory.
- DATA_W, 32, data width. Only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  execute stage presents a request
- req_ready  output  1  unit can accept a request; high only in IDLE
- MemRead  input  1  load request (from control unit)
- MemWrite  input  1  store request (from control unit)
- Funct3  input  3  instruction bits 14:12
- addr  input  DM_ADDRESS  byte address (ALU result LSBs)
- wdata  input  DATA_W  store data (rs2)
- mem_addr  output  DM_ADDRESS  word-aligned address to memory; bits [1:0] are always 0
- mem_we  output  1  memory write strobe
- mem_be  output  4  byte-lane write enables
- mem_wd  output  DATA_W  lane-shifted store data
- mem_re  output  1  memory read strobe
- mem_rd  input  DATA_W  memory read data, valid one cycle after mem_re
- resp_valid  output  1  one-cycle pulse marking transaction complete
- rdata  output  DATA_W  formatted load result; 0 for stores
- busy  output  1  high whenever state is not IDLE (pipeline stall)

Behaviour:
- Reset: state IDLE. All outputs are 0, except req_ready = 1. Reset is asynchronous and may occur mid-transaction.
- A reset mid-transaction drops the pending operation. No mem_we is issued after rst_n falls.
- Acceptance happens when req_valid && req_ready && (MemRead || MemWrite). The unit registers addr, wdata, Funct3 and the operation.
- A request with req_valid high and neither control set is ignored: no state change and no response.
- If MemRead and MemWrite are both set, the load takes priority.
- States: IDLE, ACCESS, LOAD_RSP, ERR (ERR exists only with the optional feature).
- IDLE -> ACCESS on acceptance.
- ACCESS, store:
  - mem_we = 1 with mem_be/mem_wd from the lane rules below.
  - resp_valid = 1 and rdata = 0.
  - Next state IDLE. Store latency is 1 cycle after acceptance.
- ACCESS, load: mem_re = 1; next state LOAD_RSP.
- LOAD_RSP:
  - Format mem_rd and drive rdata.
  - resp_valid = 1; next state IDLE.
  - Load latency is 2 cycles after acceptance.
- Outputs are registered. mem_* is driven only in ACCESS and is 0 otherwise. rdata holds its last value when resp_valid is low.
- Store lanes, with off = addr[1:0]:
  - SB (000): be = 0001 << off; wd = wdata[7:0] replicated to all four bytes.
  - SH (001): be = 0011 << (2*addr[1]); wd = wdata[15:0] replicated to both halves.
  - SW (010): be = 1111; wd = wdata.
  - Other Funct3 values are treated as SW.
- Load formatting:
  - LB (000): byte at lane off, sign-extended.
  - LBU (100): byte at lane off, zero-extended.
  - LH (001): halfword at addr[1], sign-extended.
  - LHU (101): halfword at addr[1], zero-extended.
  - LW (010) and all others: full word.
- Misalignment: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0.
  - Without the optional feature, the offset is forced down to the alignment boundary. Example: LW at 0x006 reads word 0x004; SH at 0x003 uses be = 1100.
- Back-to-back operation: req_ready drops the cycle after acceptance and returns in the cycle after resp_valid. Maximum throughput is one store every 2 cycles and one load every 3 cycles.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN. Adds output port misalign (1 bit, reset 0).
- When defined, a misaligned request goes IDLE -> ERR with no mem_we or mem_re issued. ERR asserts resp_valid = 1, misalign = 1, rdata = 0, then returns to IDLE.
- When undefined, there is no ERR state and no misalign port; addresses are aligned down as above.

Decomposition:
- Package lsu_pkg holds:
  - the funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum lsu_state_t;
  - the constant BYTES_PER_WORD = 4.
- Sub-module load_formatter: purely combinational. Inputs are mem_rd, the byte offset and funct3; output is the extended 32-bit result. It is instantiated in LOAD_RSP and unit-testable on its own.

Test Plan:
- SW addr = 0x010, wdata = 0xDEADBEEF -> 1 cycle after acceptance: mem_addr = 0x010, mem_be = 1111, mem_wd = 0xDEADBEEF, resp_valid = 1, rdata = 0.
- SB addr = 0x013, wdata = 0x000000A5 -> mem_be = 1000, mem_wd = 0xA5A5A5A5.
- LB addr = 0x011 with mem_rd = 0x12348000 -> rdata = 0xFFFFFF80, 2 cycles after acceptance.
  - LBU on the same inputs -> rdata = 0x00000080.
- LH addr = 0x022 with mem_rd = 0x9ABC0000 -> rdata = 0xFFFF9ABC.
  - LHU on the same inputs -> rdata = 0x00009ABC.
  - busy is high for exactly 2 cycles; req_ready is low during them.
- Reset mid-transaction: rst_n is pulsed low while in ACCESS for a store -> mem_we goes 0 immediately, no resp_valid, req_ready = 1 after release.
- LW addr = 0x006:
  - Feature off -> mem_addr = 0x004, normal response.
  - LSU_MISALIGN_TRAP_EN defined -> no mem_re; resp_valid = 1 with misalign = 1 one cycle after acceptance.
